// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default widths, the broadcast packet type and the
// round-robin selection helper used by cdb_arbiter.
package cdb_arbiter_pkg;

    localparam int CDB_DATA_WIDTH      = 32;
    localparam int CDB_ROB_ENTRY_WIDTH = 8;
    localparam int CDB_SRC_WIDTH       = 3;

    typedef struct packed {
        logic                           valid;
        logic [CDB_DATA_WIDTH-1:0]      data;
        logic [CDB_ROB_ENTRY_WIDTH-1:0] dest;
        logic [CDB_SRC_WIDTH-1:0]       src;
    } cdb_pkt_t;

    // Returns {found, index}: first set bit of req at or after ptr, wrapping modulo n.
    function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !res[3] && req[idx[2:0]]) begin
                res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-unit result buffer: small synchronous FIFO with flush, exposing its head
// entry so the arbiter can select it combinationally.
module cdb_src_fifo #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [TAG_WIDTH-1:0]  head_tag_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           cnt_q;
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign full_o      = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign do_push     = push_i & ~full_o;
    assign do_pop      = pop_i & ~empty_o;
    assign head_data_o = data_mem[rd_ptr_q];
    assign head_tag_o  = tag_mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            data_mem[wr_ptr_q] <= data_i;
            tag_mem[wr_ptr_q]  <= tag_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter feeding the registered CDB broadcast from per-unit result
// FIFOs. Define CDB_ARB_STALL_CNT_EN to add the stall_cnt backpressure counter.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU          = 3,
    parameter int FIFO_DEPTH      = 2,
    parameter int DATA_WIDTH      = CDB_DATA_WIDTH,
    parameter int ROB_ENTRY_WIDTH = CDB_ROB_ENTRY_WIDTH,
    parameter int SRC_WIDTH       = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [NUM_FU-1:0]                 fu_valid,
    input  logic [NUM_FU*DATA_WIDTH-1:0]      fu_data,
    input  logic [NUM_FU*ROB_ENTRY_WIDTH-1:0] fu_dest,
    output logic [NUM_FU-1:0]                 fu_ready,
    output logic                              cdb_valid,
    output logic [DATA_WIDTH-1:0]             cdb_data,
    output logic [ROB_ENTRY_WIDTH-1:0]        cdb_dest,
    output logic [SRC_WIDTH-1:0]              cdb_src
`ifdef CDB_ARB_STALL_CNT_EN
    ,
    output logic [31:0]                       stall_cnt
`endif
);

    logic [NUM_FU-1:0]          full;
    logic [NUM_FU-1:0]          empty;
    logic [NUM_FU-1:0]          push;
    logic [NUM_FU-1:0]          pop;
    logic [DATA_WIDTH-1:0]      head_data [NUM_FU];
    logic [ROB_ENTRY_WIDTH-1:0] head_dest [NUM_FU];

    logic [3:0]                 pick;
    logic                       cdb_valid_d, cdb_valid_q;
    logic [DATA_WIDTH-1:0]      cdb_data_d, cdb_data_q;
    logic [ROB_ENTRY_WIDTH-1:0] cdb_dest_d, cdb_dest_q;
    logic [SRC_WIDTH-1:0]       cdb_src_d, cdb_src_q;
    logic [SRC_WIDTH-1:0]       rr_ptr_d, rr_ptr_q;

    assign fu_ready = ~full;
    assign push     = fu_valid & fu_ready;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        cdb_src_fifo #(
            .DEPTH      (FIFO_DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_WIDTH  (ROB_ENTRY_WIDTH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (flush),
            .push_i      (push[i]),
            .pop_i       (pop[i]),
            .data_i      (fu_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .tag_i       (fu_dest[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH]),
            .full_o      (full[i]),
            .empty_o     (empty[i]),
            .head_data_o (head_data[i]),
            .head_tag_o  (head_dest[i])
        );
    end

    always_comb begin
        pick        = rr_pick(8'(~empty), 3'(rr_ptr_q), NUM_FU);
        pop         = '0;
        cdb_valid_d = pick[3];
        cdb_data_d  = '0;
        cdb_dest_d  = '0;
        cdb_src_d   = '0;
        rr_ptr_d    = rr_ptr_q;
        for (int k = 0; k < NUM_FU; k++) begin
            if (pick[3] && pick[2:0] == 3'(k)) begin
                pop[k]     = 1'b1;
                cdb_data_d = head_data[k];
                cdb_dest_d = head_dest[k];
                cdb_src_d  = SRC_WIDTH'(k);
                rr_ptr_d   = (k == NUM_FU - 1) ? '0 : SRC_WIDTH'(k + 1);
            end
        end
    end

    // Flush drops this edge's grant entirely: no broadcast and the pointer stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_dest_q  <= '0;
            cdb_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else if (flush) begin
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_dest_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_dest_q  <= cdb_dest_d;
            cdb_src_q   <= cdb_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_dest  = cdb_dest_q;
    assign cdb_src   = cdb_src_q;

`ifdef CDB_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (flush) begin
            stall_cnt_q <= '0;
        end else if (|(fu_valid & ~fu_ready) && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter (3 units, depth 2); per-unit expected queues
// are filled on accepted pushes and drained as broadcasts appear.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [2:0]  fu_valid;
    logic [95:0] fu_data;
    logic [23:0] fu_dest;
    logic [2:0]  fu_ready;
    logic        cdb_valid;
    logic [31:0] cdb_data;
    logic [7:0]  cdb_dest;
    logic [1:0]  cdb_src;
`ifdef CDB_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [39:0] sb0 [$];
    logic [39:0] sb1 [$];
    logic [39:0] sb2 [$];

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_FU          (3),
        .FIFO_DEPTH      (2),
        .DATA_WIDTH      (32),
        .ROB_ENTRY_WIDTH (8),
        .SRC_WIDTH       (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_data   (fu_data),
        .fu_dest   (fu_dest),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_dest  (cdb_dest),
        .cdb_src   (cdb_src)
`ifdef CDB_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "timeout");
    end

    function automatic int sb_size(input int u);
        case (u)
            0:       return sb0.size();
            1:       return sb1.size();
            2:       return sb2.size();
            default: return 0;
        endcase
    endfunction

    task automatic sb_push(input int u, input logic [39:0] v);
        case (u)
            0:       sb0.push_back(v);
            1:       sb1.push_back(v);
            default: sb2.push_back(v);
        endcase
    endtask

    task automatic sb_pop(input logic [1:0] u, output logic [39:0] v, output bit ok);
        ok = (sb_size(int'(u)) > 0);
        v  = '0;
        if (ok) begin
            case (u)
                2'd0:    v = sb0.pop_front();
                2'd1:    v = sb1.pop_front();
                default: v = sb2.pop_front();
            endcase
        end
    endtask

    task automatic sb_clear();
        sb0.delete();
        sb1.delete();
        sb2.delete();
    endtask

    task automatic set_fu(input int u, input logic [31:0] d, input logic [7:0] t);
        fu_valid[u]         = 1'b1;
        fu_data[u*32 +: 32] = d;
        fu_dest[u*8 +: 8]   = t;
    endtask

    // Record what the DUT will accept at the coming edge, then advance past it.
    task automatic tick();
        if (flush) begin
            sb_clear();
        end else begin
            for (int u = 0; u < 3; u++) begin
                if (fu_valid[u] && fu_ready[u]) sb_push(u, {fu_data[u*32 +: 32], fu_dest[u*8 +: 8]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; fu_valid = '0; fu_data = '0; fu_dest = '0;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_data !== 32'h0 || cdb_dest !== 8'h0 || cdb_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h t=%h s=%0d, want all zero", cdb_valid, cdb_data, cdb_dest, cdb_src);
        end
        checks++;
        if (fu_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: got %b want 111", fu_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b0 || cdb_data !== 32'h0 || fu_ready !== 3'b111) begin
                errors++;
                $display("FAIL idle_after_reset: cycle %0d got v=%b d=%h rdy=%b want 0/0/111", c, cdb_valid, cdb_data, fu_ready);
            end
        end
`ifdef CDB_ARB_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stall_reset: got %0d want 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_all_three();
        logic [39:0] exp;
        bit          ok;
        set_fu(0, 32'd10, 8'h01);
        set_fu(1, 32'd20, 8'h02);
        set_fu(2, 32'd30, 8'h03);
        tick();
        fu_valid = '0;
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL three_latency: got valid %b want 0 right after push edge", cdb_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b1 || cdb_src !== 2'(k)) begin
                errors++;
                $display("FAIL three_src: slot %0d got v=%b src=%0d want v=1 src=%0d", k, cdb_valid, cdb_src, k);
            end
            if (cdb_valid === 1'b1) begin
                sb_pop(cdb_src, exp, ok);
                checks++;
                if (!ok || {cdb_data, cdb_dest} !== exp) begin
                    errors++;
                    $display("FAIL three_sb: got %h/%h want %h (present=%0d)", cdb_data, cdb_dest, exp, ok);
                end
            end
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0 || cdb_data !== 32'h0) begin
            errors++;
            $display("FAIL three_idle: got v=%b d=%h want 0/0", cdb_valid, cdb_data);
        end
    endtask

    task automatic test_single();
        logic [39:0] exp;
        bit          ok;
        set_fu(1, 32'hDEADBEEF, 8'h05);
        tick();
        fu_valid = '0;
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_e0: got valid %b want 0", cdb_valid);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_data !== 32'hDEADBEEF || cdb_dest !== 8'h05 || cdb_src !== 2'd1) begin
            errors++;
            $display("FAIL single_e1: got v=%b d=%h t=%h s=%0d want 1/deadbeef/05/1", cdb_valid, cdb_data, cdb_dest, cdb_src);
        end
        if (cdb_valid === 1'b1) begin
            sb_pop(cdb_src, exp, ok);
            checks++;
            if (!ok || {cdb_data, cdb_dest} !== exp) begin
                errors++;
                $display("FAIL single_sb: got %h/%h want %h (present=%0d)", cdb_data, cdb_dest, exp, ok);
            end
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_e2: got valid %b want 0", cdb_valid);
        end
    endtask

    task automatic test_stream();
        logic [39:0] exp;
        bit          ok;
        int          low0;
        // Unit 0 alone: one broadcast per cycle, never backpressured.
        for (int k = 0; k < 8; k++) begin
            set_fu(0, 32'h1000 + 32'(k), 8'(k));
            checks++;
            if (fu_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL solo_ready: cycle %0d got fu_ready[0]=%b want 1", k, fu_ready[0]);
            end
            tick();
            if (k >= 1) begin
                checks++;
                if (cdb_valid !== 1'b1 || cdb_src !== 2'd0) begin
                    errors++;
                    $display("FAIL solo_out: cycle %0d got v=%b s=%0d want 1/0", k, cdb_valid, cdb_src);
                end
                if (cdb_valid === 1'b1) begin
                    sb_pop(cdb_src, exp, ok);
                    checks++;
                    if (!ok || {cdb_data, cdb_dest} !== exp) begin
                        errors++;
                        $display("FAIL solo_sb: got %h/%h want %h (present=%0d)", cdb_data, cdb_dest, exp, ok);
                    end
                end
            end
        end
        // Units 0 and 2 together: grants alternate and each buffer fills every other cycle.
        low0 = 0;
        for (int k = 1; k <= 10; k++) begin
            set_fu(0, 32'h2000 + 32'(k), 8'(8'h40 + k));
            set_fu(2, 32'h3000 + 32'(k), 8'(8'h80 + k));
            if (fu_ready[0] === 1'b0) low0++;
            tick();
            checks++;
            if (cdb_valid !== 1'b1 || cdb_src !== ((k % 2 == 1) ? 2'd0 : 2'd2)) begin
                errors++;
                $display("FAIL alt_src: step %0d got v=%b s=%0d want 1/%0d", k, cdb_valid, cdb_src, (k % 2 == 1) ? 0 : 2);
            end
            if (cdb_valid === 1'b1) begin
                sb_pop(cdb_src, exp, ok);
                checks++;
                if (!ok || {cdb_data, cdb_dest} !== exp) begin
                    errors++;
                    $display("FAIL alt_sb: got %h/%h want %h (present=%0d)", cdb_data, cdb_dest, exp, ok);
                end
            end
        end
        fu_valid = '0;
        checks++;
        if (low0 != 4) begin
            errors++;
            $display("FAIL alt_ready0_low: got %0d cycles want 4", low0);
        end
`ifdef CDB_ARB_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd8) begin
            errors++;
            $display("FAIL stall_alt: got %0d want 8", stall_cnt);
        end
`endif
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cdb_valid === 1'b1) begin
                sb_pop(cdb_src, exp, ok);
                checks++;
                if (!ok || {cdb_data, cdb_dest} !== exp) begin
                    errors++;
                    $display("FAIL drain_sb: got %h/%h want %h (present=%0d)", cdb_data, cdb_dest, exp, ok);
                end
            end
        end
        checks++;
        if (cdb_valid !== 1'b0 || sb_size(0) + sb_size(1) + sb_size(2) != 0) begin
            errors++;
            $display("FAIL drain_done: got v=%b outstanding=%0d want 0/0", cdb_valid, sb_size(0) + sb_size(1) + sb_size(2));
        end
    endtask

    task automatic test_flush();
        logic [39:0] exp;
        bit          ok;
        set_fu(0, 32'h4000, 8'h10);
        set_fu(1, 32'h4001, 8'h11);
        set_fu(2, 32'h4002, 8'h12);
        tick();
        fu_valid = '0;
        set_fu(2, 32'h4003, 8'h13);
        tick();
        fu_valid = '0;
        checks++;
        if (fu_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill: got fu_ready[2]=%b want 0 with two entries", fu_ready[2]);
        end
        if (cdb_valid === 1'b1) begin
            sb_pop(cdb_src, exp, ok);
            checks++;
            if (!ok || {cdb_data, cdb_dest} !== exp) begin
                errors++;
                $display("FAIL flush_pre_sb: got %h/%h want %h (present=%0d)", cdb_data, cdb_dest, exp, ok);
            end
        end
        flush = 1'b1;
        set_fu(0, 32'hBAD0, 8'hE0);
        set_fu(2, 32'hBAD2, 8'hE2);
        tick();
        flush = 1'b0;
        fu_valid = '0;
        checks++;
        if (cdb_valid !== 1'b0 || fu_ready !== 3'b111) begin
            errors++;
            $display("FAIL flush_edge: got v=%b rdy=%b want 0/111", cdb_valid, fu_ready);
        end
`ifdef CDB_ARB_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stall_flush: got %0d want 0", stall_cnt);
        end
`endif
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_stale: cycle %0d got valid=1 src=%0d d=%h want 0", c, cdb_src, cdb_data);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [39:0] exp;
        bit          ok;
        set_fu(0, 32'h5000, 8'h20);
        set_fu(1, 32'h5001, 8'h21);
        set_fu(2, 32'h5002, 8'h22);
        tick();
        fu_valid = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset_out: cycle %0d got valid %b want 1", c, cdb_valid);
            end
            if (cdb_valid === 1'b1) begin
                sb_pop(cdb_src, exp, ok);
                checks++;
                if (!ok || {cdb_data, cdb_dest} !== exp) begin
                    errors++;
                    $display("FAIL pre_reset_sb: got %h/%h want %h (present=%0d)", cdb_data, cdb_dest, exp, ok);
                end
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_data !== 32'h0 || fu_ready !== 3'b111) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h rdy=%b want 0/0/111", cdb_valid, cdb_data, fu_ready);
        end
        sb_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_stale: cycle %0d got valid=1 src=%0d d=%h want 0", c, cdb_src, cdb_data);
            end
        end
        // Pointer must be back at 0: a fresh triple broadcasts 0, 1, 2.
        set_fu(0, 32'h6000, 8'h30);
        set_fu(1, 32'h6001, 8'h31);
        set_fu(2, 32'h6002, 8'h32);
        tick();
        fu_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b1 || cdb_src !== 2'(k)) begin
                errors++;
                $display("FAIL post_reset_rr: slot %0d got v=%b s=%0d want 1/%0d", k, cdb_valid, cdb_src, k);
            end
            if (cdb_valid === 1'b1) begin
                sb_pop(cdb_src, exp, ok);
                checks++;
                if (!ok || {cdb_data, cdb_dest} !== exp) begin
                    errors++;
                    $display("FAIL post_reset_sb: got %h/%h want %h (present=%0d)", cdb_data, cdb_dest, exp, ok);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_three();
        test_single();
        test_stream();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
